// File: rtl/datapath_rf.sv
// -----------------------------------------------------------------------------
// datapath_rf
// Register-file datapath with an 8-function ALU, registered N/Z/C/V flags and a
// two-stage pipeline (issue/capture, then execute/write-back). Results are
// forwarded from stage 1 to an op issuing in the same cycle. This allows one op
// to issue every cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   din        external operand; becomes the result when src_sel=1
//   op_valid   issue an operation this cycle
//   src_sel    0 = ALU result, 1 = din
//   fn         ALU function (ADD SUB AND OR XOR PASSA SHL1 SHR1)
//   ra_addr    operand A register address
//   rb_addr    operand B register address
//   wr_addr    destination register address
//   dout       last result (registered)
//   res_valid  one-cycle pulse when dout/flags are updated
//   N Z C V    negative, zero, carry/no-borrow/shift-out, signed overflow
// -----------------------------------------------------------------------------
module datapath_rf #(
    parameter int W  = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  din,
    input  logic          op_valid,
    input  logic          src_sel,
    input  logic [2:0]    fn,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    input  logic [AW-1:0] wr_addr,
    output logic [W-1:0]  dout,
    output logic          res_valid,
    output logic          N,
    output logic          Z,
    output logic          C,
    output logic          V
);

    localparam int NREGS = 2 ** AW;

    localparam logic [2:0] FN_ADD  = 3'b000;
    localparam logic [2:0] FN_SUB  = 3'b001;
    localparam logic [2:0] FN_AND  = 3'b010;
    localparam logic [2:0] FN_OR   = 3'b011;
    localparam logic [2:0] FN_XOR  = 3'b100;
    localparam logic [2:0] FN_PASS = 3'b101;
    localparam logic [2:0] FN_SHL1 = 3'b110;
    localparam logic [2:0] FN_SHR1 = 3'b111;

    // Register file. It is cleared on reset, so it is built from flops.
    logic [W-1:0]  rf_q [NREGS];

    // Stage-1 (execute) registers
    logic          s1_valid_q;
    logic [W-1:0]  s1_a_q;
    logic [W-1:0]  s1_b_q;
    logic [W-1:0]  s1_din_q;
    logic [2:0]    s1_fn_q;
    logic          s1_src_q;
    logic [AW-1:0] s1_wr_q;

    // Output registers
    logic [W-1:0]  dout_q;
    logic          res_valid_q;
    logic          n_q, z_q, c_q, v_q;

    // Stage-1 combinational result
    logic [W-1:0]  result_d;
    logic          c_d, v_d;
    logic [W:0]    sum_d;
    logic [W:0]    diff_d;

    // Operands for the op issuing now, after forwarding
    logic [W-1:0]  opa_d, opb_d;

    always_comb begin
        sum_d    = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        diff_d   = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        result_d = '0;
        c_d      = 1'b0;
        v_d      = 1'b0;
        if (s1_src_q) begin
            result_d = s1_din_q;
        end else begin
            case (s1_fn_q)
                FN_ADD: begin
                    result_d = sum_d[W-1:0];
                    c_d      = sum_d[W];
                    // Same-sign operands producing a different-sign result
                    v_d      = (s1_a_q[W-1] == s1_b_q[W-1]) &&
                               (sum_d[W-1] != s1_a_q[W-1]);
                end
                FN_SUB: begin
                    result_d = diff_d[W-1:0];
                    c_d      = ~diff_d[W];      // carry means "no borrow"
                    v_d      = (s1_a_q[W-1] != s1_b_q[W-1]) &&
                               (diff_d[W-1] != s1_a_q[W-1]);
                end
                FN_AND:  result_d = s1_a_q & s1_b_q;
                FN_OR:   result_d = s1_a_q | s1_b_q;
                FN_XOR:  result_d = s1_a_q ^ s1_b_q;
                FN_PASS: result_d = s1_a_q;
                FN_SHL1: begin
                    result_d = {s1_a_q[W-2:0], 1'b0};
                    c_d      = s1_a_q[W-1];
                end
                FN_SHR1: begin
                    result_d = {1'b0, s1_a_q[W-1:1]};
                    c_d      = s1_a_q[0];
                end
                default: result_d = '0;
            endcase
        end
    end

    // The result being written this edge bypasses the RF for the issuing op.
    always_comb begin
        opa_d = rf_q[ra_addr];
        opb_d = rf_q[rb_addr];
        if (s1_valid_q && (s1_wr_q == ra_addr)) opa_d = result_d;
        if (s1_valid_q && (s1_wr_q == rb_addr)) opb_d = result_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_din_q    <= '0;
            s1_fn_q     <= '0;
            s1_src_q    <= 1'b0;
            s1_wr_q     <= '0;
            dout_q      <= '0;
            res_valid_q <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            // Stage 0: capture
            s1_valid_q <= op_valid;
            if (op_valid) begin
                s1_a_q   <= opa_d;
                s1_b_q   <= opb_d;
                s1_din_q <= din;
                s1_fn_q  <= fn;
                s1_src_q <= src_sel;
                s1_wr_q  <= wr_addr;
            end
            // Stage 1: write back
            res_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rf_q[s1_wr_q] <= result_d;
                dout_q        <= result_d;
                n_q           <= result_d[W-1];
                z_q           <= (result_d == '0);
                c_q           <= c_d;
                v_q           <= v_d;
            end
        end
    end

    assign dout      = dout_q;
    assign res_valid = res_valid_q;
    assign N         = n_q;
    assign Z         = z_q;
    assign C         = c_q;
    assign V         = v_q;

endmodule

// File: doc/datapath_rf.md
Name: datapath_rf

Overview:
- Parametrised successor to the two-register GCD-style datapath.
- Replaces fixed A/B registers with a 2^AW-entry register file (two read ports, one write port) and widens the ALU to 8 functions.
- Adds registered N/Z/C/V flags and a 2-stage pipeline with result forwarding, so one op can issue every cycle.
- Driven by a controller FSM; dout feeds the output buffer.

Parameters:
W, 16, data width in bits
AW, 2, register-file address width; NREGS = 2**AW entries

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
din  input  W  external operand (AB path)
op_valid  input  1  issue an operation this cycle
src_sel  input  1  0 = ALU result, 1 = din is the result
fn  input  3  ALU function
ra_addr  input  AW  read address, operand A
rb_addr  input  AW  read address, operand B
wr_addr  input  AW  destination register
dout  output  W  last result (registered)
res_valid  output  1  1-cycle pulse: dout/flags updated
N  output  1  negative flag
Z  output  1  zero flag
C  output  1  carry / no-borrow / shifted-out bit
V  output  1  signed overflow flag

Behaviour:
- Reset (reset=0, async): all RF entries, dout, N, Z, C, V, res_valid and stage-1 valid cleared to 0. Any in-flight op is discarded and never writes back.
- Stage 0 (issue edge E0, op_valid=1): stage-1 register captures opA=RF[ra_addr], opB=RF[rb_addr], din, fn, src_sel, wr_addr, s1_valid=1. op_valid=0 at E0 sets s1_valid=0.
- Stage 1 (cycle after E0): result computed combinationally from stage-1 regs.
- At E1, if s1_valid:
  - RF[wr_addr] <= result
  - dout <= result
  - flags updated
  - res_valid=1 for one cycle
- Latency: 2 edges from issue to dout/res_valid. Throughput: 1 op/cycle. No backpressure.
- Forwarding: if s1_valid and s1_wr_addr equals ra_addr (or rb_addr) of the op issuing this cycle, the operand takes the stage-1 result instead of RF. Applies to both ports independently. No other hazard exists.
- Same-op read/write to one address: reads pre-write value (or forwarded value).
- fn encoding (A=opA, B=opB, arithmetic on W+1 bits):
  - 000 ADD: A+B
  - 001 SUB: A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 PASSA
  - 110 SHL1: logical shift left by 1
  - 111 SHR1: logical shift right by 1
- Flags, all ops: N = result[W-1]; Z = (result == 0).
- C by op:
  - ADD: carry out
  - SUB: 1 when no borrow (A >= B unsigned)
  - SHL1: A[W-1]
  - SHR1: A[0]
  - logic/PASSA: 0
- V: two's-complement overflow for ADD/SUB; 0 otherwise.
- src_sel=1: result = captured din; N/Z from din; C=V=0; fn ignored.
- No valid op at E1: dout, flags and RF hold; res_valid=0.
- Arithmetic wraps modulo 2^W. No saturation.

Test Plan:
- Load: issue din=0x0005 src_sel=1 wr=0, next cycle din=0x0003 wr=1 -> res_valid on edges 2 and 3; dout 0x0005 then 0x0003; N=Z=C=V=0.
- Forwarding: back-to-back SUB r2=r0-r1, then ADD r3=r2+r0 -> dout 0x0002 then 0x0007; RF[3]=0x0007.
- SUB borrow: SUB r1-r0 (3-5) -> 0xFFFE, N=1 Z=0 C=0 V=0.
- Overflow and zero:
  - Load 0x7FFF and 0x0001, then ADD -> 0x8000, N=1 V=1 C=0.
  - SUB r0-r0 -> 0x0000, Z=1 C=1.
- Shifts:
  - SHL1 on 0x8001 -> 0x0002, C=1.
  - SHR1 on 0x0001 -> 0x0000, Z=1 C=1.
- Reset and idle:
  - Assert reset with an op in stage 1 -> res_valid stays 0, all outputs 0, RF reads 0; ops issued after release behave normally.
  - op_valid=0 for 5 cycles -> dout and flags hold.
